// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, frame bit
// positions, the per-byte receive status record and the parity check helper.
package uart_pkg;

    // Data bits per frame; fixed by the 11-bit start/8-data/parity/stop format.
    localparam int DATA_W  = 8;
    localparam int FRAME_W = 11;

    // Parity modes as presented on parity_type (2'b11 also means none).
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Bit positions inside frame_in; d0 sits at FRM_D0 and d7 at FRM_D0-7.
    localparam int FRM_START = 10;
    localparam int FRM_D0    = 9;
    localparam int FRM_PAR   = 1;
    localparam int FRM_STOP  = 0;

    // Status stored alongside each received byte.
    typedef struct packed {
        logic start_err;
        logic parity_err;
        logic frame_err;
    } rx_status_t;

    // Parity error for one byte plus its parity bit under the given mode.
    function automatic logic parity_err_f(input logic [DATA_W-1:0] data,
                                          input logic              par_bit,
                                          input logic [1:0]        mode);
        logic err;
        case (mode)
            PAR_ODD:  err = ~(^{data, par_bit});
            PAR_EVEN: err = ^{data, par_bit};
            default:  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO: push/pop, full/empty and occupancy count.
// Pointers are log2(DEPTH) bits and wrap naturally, so DEPTH must be a
// power of two. A push while full is accepted only together with a pop.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       baud_clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage write; contents need no reset because reads are gated by empty.
    always_ff @(posedge baud_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push+pop leaves count alone.
    always_ff @(posedge baud_clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures one completed frame per frame_flag
// assertion, decodes data and status, queues them in uart_rx_fifo and
// presents the head entry through a valid/ready handshake. Dropped frames
// (FIFO full with no pop) raise a sticky overrun flag.
// Build option: define UART_RX_CTRL_PARITY_EN to enable the parity check;
// without it parity_type and the frame's parity bit are ignored.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       baud_clk,
    input  logic                       reset_n,
    input  logic [10:0]                frame_in,
    input  logic                       frame_flag,
    input  logic [1:0]                 parity_type,
    input  logic                       rd_ready,
    input  logic                       err_clr,
    output logic                       rd_valid,
    output logic [7:0]                 rd_data,
    output logic [2:0]                 rd_status,
    output logic                       overrun,
    output logic [$clog2(DEPTH):0]     count
);

    logic                flag_q_r;
    logic                overrun_r;
    logic                capture_s;
    logic                push_s;
    logic                pop_s;
    logic                drop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [DATA_W-1:0]   data_s;
    rx_status_t          status_s;
    logic [FRAME_W-1:0]  entry_s;
    logic [FRAME_W-1:0]  head_s;

    assign capture_s = frame_flag && !flag_q_r;
    assign pop_s     = rd_ready && !fifo_empty_s;
    assign push_s    = capture_s && (!fifo_full_s || pop_s);
    assign drop_s    = capture_s && fifo_full_s && !pop_s;
    assign entry_s   = {status_s, data_s};
    assign rd_valid  = !fifo_empty_s;
    assign overrun   = overrun_r;

    // Frame-flag edge detector; resets high so a flag held across reset is ignored.
    always_ff @(posedge baud_clk) begin
        if (!reset_n) begin
            flag_q_r <= 1'b1;
        end else begin
            flag_q_r <= frame_flag;
        end
    end

    // Field decode: reverse the on-wire d0-first order and derive status bits.
    always_comb begin
        data_s   = {DATA_W{1'b0}};
        status_s = '{start_err: 1'b0, parity_err: 1'b0, frame_err: 1'b0};
        for (int i = 0; i < DATA_W; i++) begin
            data_s[i] = frame_in[FRM_D0 - i];
        end
        status_s.start_err = frame_in[FRM_START];
        status_s.frame_err = ~frame_in[FRM_STOP];
`ifdef UART_RX_CTRL_PARITY_EN
        status_s.parity_err = parity_err_f(data_s, frame_in[FRM_PAR], parity_type);
`else
        status_s.parity_err = 1'b0;
`endif
    end

`ifndef UART_RX_CTRL_PARITY_EN
    // Parity inputs have no function in this build.
    logic unused_parity_s;
    assign unused_parity_s = &{1'b0, parity_type, frame_in[FRM_PAR]};
`endif

    // Sticky overrun: a drop wins over a same-cycle clear.
    always_ff @(posedge baud_clk) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (err_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Head presentation; forced to zero while the queue is empty.
    always_comb begin
        rd_data   = 8'h00;
        rd_status = 3'b000;
        if (fifo_empty_s) begin
            rd_data   = 8'h00;
            rd_status = 3'b000;
        end else begin
            rd_data   = head_s[DATA_W-1:0];
            rd_status = head_s[FRAME_W-1:DATA_W];
        end
    end

    uart_rx_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .push     (push_s),
        .wr_data  (entry_s),
        .pop      (pop_s),
        .rd_data  (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (count)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=4).
// Frame constants are hand-encoded: {start, d0..d7, parity, stop}.
module tb_uart_rx_ctrl;

    logic        baud_clk;
    logic        reset_n;
    logic [10:0] frame_in;
    logic        frame_flag;
    logic [1:0]  parity_type;
    logic        rd_ready;
    logic        err_clr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [2:0]  rd_status;
    logic        overrun;
    logic [2:0]  count;

    int n_tests;
    int n_fail;

    uart_rx_ctrl #(.DEPTH(4)) dut (
        .baud_clk    (baud_clk),
        .reset_n     (reset_n),
        .frame_in    (frame_in),
        .frame_flag  (frame_flag),
        .parity_type (parity_type),
        .rd_ready    (rd_ready),
        .err_clr     (err_clr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_status   (rd_status),
        .overrun     (overrun),
        .count       (count)
    );

    // Free-running baud clock.
    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge baud_clk);
        #1;
    endtask

    task automatic send_frame(input logic [10:0] f, input int len);
        frame_in   = f;
        frame_flag = 1'b1;
        tick(len);
        frame_flag = 1'b0;
        tick(1);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    logic [7:0] drain_exp [4];

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        frame_in    = 11'h000;
        frame_flag  = 1'b0;
        parity_type = 2'b00;
        rd_ready    = 1'b0;
        err_clr     = 1'b0;
        tick(2);

        check_eq("rst_valid",   {31'd0, rd_valid}, 32'd0);
        check_eq("rst_count",   {29'd0, count},    32'd0);
        check_eq("rst_overrun", {31'd0, overrun},  32'd0);
        check_eq("rst_data",    {24'd0, rd_data},  32'd0);
        check_eq("rst_status",  {29'd0, rd_status}, 32'd0);
        reset_n = 1'b1;
        tick(1);

        // 0x5A, odd parity correct (1), 3-cycle flag -> one entry.
        parity_type = 2'b01;
        send_frame(11'h16B, 3);
        check_eq("t1_count",  {29'd0, count},     32'd1);
        check_eq("t1_valid",  {31'd0, rd_valid},  32'd1);
        check_eq("t1_data",   {24'd0, rd_data},   32'h5A);
        check_eq("t1_status", {29'd0, rd_status}, 32'd0);
        pop_one();
        check_eq("t1_popped", {29'd0, count}, 32'd0);

        // 0x01: d0 at frame bit 9 -> bit-order check.
        send_frame(11'h201, 1);
        check_eq("rev_data",   {24'd0, rd_data},   32'h01);
        check_eq("rev_status", {29'd0, rd_status}, 32'd0);
        pop_one();

        // Even mode, wrong parity and stop bit 0.
        parity_type = 2'b10;
        send_frame(11'h16A, 1);
`ifdef UART_RX_CTRL_PARITY_EN
        check_eq("even_bad", {29'd0, rd_status}, 32'b011);
`else
        check_eq("even_bad", {29'd0, rd_status}, 32'b001);
`endif
        pop_one();
        parity_type = 2'b11;
        send_frame(11'h16A, 1);
        check_eq("none_bad", {29'd0, rd_status}, 32'b001);
        pop_one();

        // Odd mode, bad parity, good stop.
        parity_type = 2'b01;
        send_frame(11'h169, 1);
`ifdef UART_RX_CTRL_PARITY_EN
        check_eq("odd_bad", {29'd0, rd_status}, 32'b010);
`else
        check_eq("odd_bad", {29'd0, rd_status}, 32'b000);
`endif
        pop_one();

        // Fill with 0x11,0x22,0x33,0x44 then overflow with 0x55.
        parity_type = 2'b00;
        send_frame(11'h221, 1);
        send_frame(11'h111, 1);
        send_frame(11'h331, 1);
        send_frame(11'h089, 1);
        check_eq("full_count",   {29'd0, count},   32'd4);
        check_eq("full_overrun", {31'd0, overrun}, 32'd0);
        send_frame(11'h2A9, 1);
        check_eq("ovr_count", {29'd0, count},   32'd4);
        check_eq("ovr_flag",  {31'd0, overrun}, 32'd1);
        check_eq("ovr_head",  {24'd0, rd_data}, 32'h11);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check_eq("ovr_clr", {31'd0, overrun}, 32'd0);

        // Drop and clear in the same cycle: set wins.
        frame_in   = 11'h2A9;
        frame_flag = 1'b1;
        err_clr    = 1'b1;
        tick(1);
        err_clr    = 1'b0;
        frame_flag = 1'b0;
        tick(1);
        check_eq("ovr_set_prio", {31'd0, overrun}, 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check_eq("ovr_clr2", {31'd0, overrun}, 32'd0);

        // Full, capture coincides with pop -> both succeed.
        frame_in   = 11'h2A9;
        frame_flag = 1'b1;
        rd_ready   = 1'b1;
        tick(1);
        rd_ready   = 1'b0;
        tick(1);
        frame_flag = 1'b0;
        tick(1);
        check_eq("pp_count",   {29'd0, count},   32'd4);
        check_eq("pp_overrun", {31'd0, overrun}, 32'd0);

        drain_exp[0] = 8'h22;
        drain_exp[1] = 8'h33;
        drain_exp[2] = 8'h44;
        drain_exp[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain_data%0d", i), {24'd0, rd_data}, {24'd0, drain_exp[i]});
            check_eq($sformatf("drain_stat%0d", i), {29'd0, rd_status}, 32'd0);
            pop_one();
        end
        check_eq("drain_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("drain_count", {29'd0, count},    32'd0);

        // rd_ready while empty has no effect.
        rd_ready = 1'b1;
        tick(2);
        rd_ready = 1'b0;
        check_eq("empty_pop_count", {29'd0, count}, 32'd0);
        check_eq("empty_pop_data",  {24'd0, rd_data}, 32'd0);

        // Flag held high across reset release is not captured.
        frame_in   = 11'h16B;
        frame_flag = 1'b1;
        reset_n    = 1'b0;
        tick(2);
        reset_n    = 1'b1;
        tick(3);
        check_eq("rst_flag_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("rst_flag_count", {29'd0, count},    32'd0);
        frame_flag = 1'b0;
        tick(1);

        // Reset with two entries flushes the queue.
        send_frame(11'h221, 1);
        send_frame(11'h111, 1);
        check_eq("two_count", {29'd0, count}, 32'd2);
        reset_n = 1'b0;
        tick(1);
        check_eq("flush_count", {29'd0, count},    32'd0);
        check_eq("flush_valid", {31'd0, rd_valid}, 32'd0);
        reset_n = 1'b1;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between the UART-Rx serial-to-parallel shift register and the host. Captures each completed 11-bit frame once per frame, decodes start/data/parity/stop fields, checks them against the configured parity mode, and buffers data plus per-byte status in a small FIFO. The host drains bytes through a valid/ready handshake. Overrun is reported as a sticky flag.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- DATA_W, 8, data bits per frame; fixed by the 11-bit frame format

- baud_clk  in  1  single clock for the whole block; the same baud clock that drives the shift register
- reset_n  in  1  synchronous, active-low reset
- frame_in  in  11  parallel frame; [10]=start, [9:2]=d0..d7 (d0 at [9]), [1]=parity, [0]=stop
- frame_flag  in  1  high for ≥1 cycle while frame_in holds a completed frame
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none
- rd_ready  in  1  host accepts the head entry
- err_clr  in  1  clears the sticky overrun flag
- rd_valid  out  1  FIFO non-empty
- rd_data  out  8  head byte, d7..d0 in normal bit order
- rd_status  out  3  head status {start_err, parity_err, frame_err}
- overrun  out  1  sticky; a frame was dropped
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Edge detector: flag_q <= frame_flag. A capture happens when frame_flag && !flag_q. Exactly one capture per flag assertion, whatever its length.
- Decode on capture:
  - rd_data[i] = frame_in[9-i]
  - start_err = frame_in[10]
  - frame_err = !frame_in[0]
  - parity_err = (mode odd) ? ~^{data,parity} : (mode even) ? ^{data,parity} : 0
- Errored frames are still stored, with their status bits set. No frame is silently discarded except on overrun.
- Push is accepted if !full, or if full and a pop occurs in the same cycle.
- If full and no pop: frame dropped, overrun <= 1, FIFO unchanged.
- Pop = rd_valid && rd_ready. rd_ready while empty has no effect.
- overrun: set has priority over err_clr in the same cycle. Otherwise err_clr clears it.
- parity_type is sampled at capture only. Changing it mid-frame affects only later captures.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count tracks occupancy: +1 on push only, −1 on pop only, unchanged on push+pop.

## Timing
- Reset (reset_n low at a baud_clk edge):
  - rd_valid=0, count=0, overrun=0
  - rd_data=0, rd_status=0
  - pointers=0
  - flag_q=1, so a frame_flag already high at reset release is not captured
- Capture latency: frame_flag rises before edge N (first sampled high at N). The entry is written at N, and rd_valid/rd_data/rd_status are valid after N (visible in cycle N+1).
- Pop: the head advances at the edge where rd_valid && rd_ready. The next entry (or rd_valid=0) appears the following cycle.
- rd_data/rd_status are combinational reads of registered storage indexed by the read pointer. They are stable while rd_valid && !rd_ready.
- Reset mid-operation flushes all entries. Any frame captured in the reset cycle is lost.

## Configuration
- UART_RX_CTRL_PARITY_EN defined: parity check active as above; parity_type is honoured.
- Not defined:
  - parity_type is ignored and the parity bit frame_in[1] is ignored
  - parity_err is always 0
  - the parity XOR logic is absent

## Structure
- Shared package uart_pkg holds:
  - parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN)
  - frame bit-position constants (FRM_START=10, FRM_D0=9, FRM_PAR=1, FRM_STOP=0)
  - rx status struct {start_err, parity_err, frame_err}
- Sub-module uart_rx_fifo: generic synchronous FIFO with push/pop, full/empty and count, WIDTH=11, DEPTH parameter. uart_rx_ctrl owns edge detection, decode, overrun and the handshake.

## Test plan
- Frame 0 0x5A odd-parity-correct 1 (parity_type=01), 3-cycle flag, rd_ready=0 → one entry; rd_data=0xA5 reversal check fails unless d0..d7 mapped; expect rd_data=0x5A, rd_status=000, count=1.
- Even mode, frame with wrong parity and stop bit 0 → rd_status=011. Same frame with parity_type=11 → rd_status=001.
- Five frames with DEPTH=4 and rd_ready=0 → count=4, overrun=1, first four bytes read back in order. err_clr then clears overrun. overrun set together with err_clr → overrun stays 1.
- FIFO full, capture coincides with rd_ready=1 → pop and push both succeed, count stays 4, overrun=0.
- frame_flag held high across reset release → no capture, rd_valid=0. Reset asserted with 2 entries → count=0 next cycle.
- UART_RX_CTRL_PARITY_EN undefined, bad-parity frame in odd mode → rd_status=000.
